issueq_int: RTL
===============

Name: issueq_int

Overview:
- Integer issue queue; receiving end of the dispatch→execution-queue interface (equeue_*/equeueint_* bus, en/ready handshake).
- Buffers up to DEPTH integer/branch ops and snoops the CDB for pending source tags.
- Selects the oldest entry with both operands valid and issues it to the integer ALU over a valid/ready handshake.

Parameters:
- DEPTH, 4, number of queue entries (≥2).
- W_TAG, 6, tag width; matches the tag FIFO and register status table.
- W_DATA, 32, operand data width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- dispatch_en  input  1  dispatch writes one entry this cycle.
- dispatch_ready  output  1  queue can accept an entry this cycle.
- dispatch_opcode  input  6  R-type funct, or BEQ/BNE opcode.
- dispatch_imm  input  16  raw immediate.
- dispatch_rdtag  input  W_TAG  destination tag.
- dispatch_rstag  input  W_TAG  RS producer tag.
- dispatch_rttag  input  W_TAG  RT producer tag.
- dispatch_rsdata  input  W_DATA  RS data; meaningful when rsvalid=1.
- dispatch_rtdata  input  W_DATA  RT data; meaningful when rtvalid=1.
- dispatch_rsvalid  input  1  RS data present.
- dispatch_rtvalid  input  1  RT data present.
- cdb_tag  input  W_TAG  broadcast tag.
- cdb_valid  input  1  broadcast valid.
- cdb_data  input  W_DATA  broadcast data.
- issue_valid  output  1  an issuable entry is presented.
- issue_ready  input  1  ALU accepts the presented entry.
- issue_opcode  output  6  opcode of the presented entry.
- issue_imm  output  16  immediate of the presented entry.
- issue_rdtag  output  W_TAG  destination tag of the presented entry.
- issue_rsdata  output  W_DATA  RS operand of the presented entry.
- issue_rtdata  output  W_DATA  RT operand of the presented entry.
- count  output  clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Storage: compacting shift queue. Entry 0 is the oldest; occupied entries are contiguous from index 0. Each entry holds valid, opcode, imm, rdtag, rstag, rttag, rsdata, rtdata, rsvalid, rtvalid.
- Reset (reset=0, async): all entry valid bits cleared, count=0. All issue_* outputs are 0 and dispatch_ready=1 while reset is asserted and after release. A reset mid-operation discards all entries with no issue.
- dispatch_ready = (count < DEPTH), combinational from registers.
- Dispatch handshake: an entry is accepted only when dispatch_en && dispatch_ready; dispatch_en while not ready is ignored with no state change. The accepted entry lands at index count (or count-1 if an issue occurs the same cycle).
- Selection: issue_valid = OR over occupied entries of (rsvalid && rtvalid). The selected entry is the lowest index satisfying this. When issue_valid=0, all issue_* data outputs are 0.
- Issue: on issue_valid && issue_ready, the selected entry is removed. Entries above it shift down by one, entries below it are unchanged, and count decrements.
- Latency: an entry accepted with both operands valid can issue at the earliest on the next cycle (no dispatch→issue bypass).
- CDB snoop: each cycle, for every occupied entry with rsvalid=0 and rstag==cdb_tag && cdb_valid, capture cdb_data into rsdata and set rsvalid. RT is handled the same way. The entry becomes issuable the following cycle.
- Incoming dispatch entry: it is also snooped in the same cycle. An operand with valid=0 and a tag matching the CDB is stored as valid with cdb_data.
- Simultaneous events: dispatch, issue and CDB capture in one cycle must all take effect. A shifted entry carries its CDB-updated operands; count is unchanged when one entry is dispatched and one issued.
- No flush: dispatch stalls on branches, so no speculative entries exist.

Optional Feature:
- Macro: ISSUEQ_FULL_PASS_EN.
- Defined: dispatch_ready = (count < DEPTH) || (issue_valid && issue_ready). A full queue accepts a new entry in the same cycle one issues; the new entry lands at index DEPTH-1. This adds a combinational path issue_ready→dispatch_ready.
- Undefined: dispatch_ready depends on count only.

Test Plan:
- Reset then dispatch ADD (opcode 0x20, rs=5, rt=7, both valid, rdtag=3) with issue_ready=1 → issue_valid=1 the next cycle with rsdata=5, rtdata=7, rdtag=3; count returns to 0.
- Dispatch entry A (rstag=9, rsvalid=0, rt valid) then entry B (both valid) with issue_ready=1 → B issues first. CDB tag 9 with data 0x11 → A issues the following cycle with rsdata=0x11.
- Fill 4 entries, all operands invalid → dispatch_ready=0 and a 5th dispatch_en is ignored with count=4. Broadcast matching tags → entries issue oldest-first and count reaches 0.
- Same cycle: dispatch entry with rttag=12 pending, CDB tag=12 data=0xABCD, and issue of entry 0 → new entry stored with rtdata=0xABCD and valid; count unchanged.
- Assert reset low with 3 entries queued → count=0, issue_valid=0 and dispatch_ready=1 immediately, without waiting for a clock edge.
- With ISSUEQ_FULL_PASS_EN, full queue, issue_ready=1 and dispatch_en=1 → dispatch_ready=1, new entry accepted, count stays 4. Without the macro, dispatch_ready=0.

Source files
------------

// File: rtl/issueq_int.sv
// issueq_int: integer issue queue.
// Compacting shift queue of DEPTH entries (entry 0 oldest). Snoops the CDB
// for pending source operands and issues the oldest fully-ready entry to the
// integer ALU over a valid/ready handshake.
// Optional macro ISSUEQ_FULL_PASS_EN: a full queue may accept a dispatch in the
// same cycle an entry issues (adds an issue_ready -> dispatch_ready path).
module issueq_int #(
    parameter int DEPTH  = 4,
    parameter int W_TAG  = 6,
    parameter int W_DATA = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dispatch_en,
    output logic                       dispatch_ready,
    input  logic [5:0]                 dispatch_opcode,
    input  logic [15:0]                dispatch_imm,
    input  logic [W_TAG-1:0]           dispatch_rdtag,
    input  logic [W_TAG-1:0]           dispatch_rstag,
    input  logic [W_TAG-1:0]           dispatch_rttag,
    input  logic [W_DATA-1:0]          dispatch_rsdata,
    input  logic [W_DATA-1:0]          dispatch_rtdata,
    input  logic                       dispatch_rsvalid,
    input  logic                       dispatch_rtvalid,
    input  logic [W_TAG-1:0]           cdb_tag,
    input  logic                       cdb_valid,
    input  logic [W_DATA-1:0]          cdb_data,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [5:0]                 issue_opcode,
    output logic [15:0]                issue_imm,
    output logic [W_TAG-1:0]           issue_rdtag,
    output logic [W_DATA-1:0]          issue_rsdata,
    output logic [W_DATA-1:0]          issue_rtdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int W_CNT = $clog2(DEPTH + 1);
    localparam int W_IDX = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [5:0]        opcode;
        logic [15:0]       imm;
        logic [W_TAG-1:0]  rdtag;
        logic [W_TAG-1:0]  rstag;
        logic [W_TAG-1:0]  rttag;
        logic [W_DATA-1:0] rsdata;
        logic [W_DATA-1:0] rtdata;
        logic              rsvalid;
        logic              rtvalid;
    } entry_t;

    // Capture a CDB broadcast into any pending operand of one entry.
    function automatic entry_t snoop_fn(input entry_t e, input logic cv,
                                        input logic [W_TAG-1:0] ct,
                                        input logic [W_DATA-1:0] cd);
        entry_t r;
        r = e;
        if (cv && !e.rsvalid && (e.rstag == ct)) begin
            r.rsvalid = 1'b1;
            r.rsdata  = cd;
        end else begin
            r.rsvalid = e.rsvalid;
        end
        if (cv && !e.rtvalid && (e.rttag == ct)) begin
            r.rtvalid = 1'b1;
            r.rtdata  = cd;
        end else begin
            r.rtvalid = e.rtvalid;
        end
        return r;
    endfunction

    entry_t             q_r       [DEPTH];
    logic [DEPTH-1:0]   valid_r;
    logic [W_CNT-1:0]   count_r;

    entry_t             snp_s     [DEPTH+1];
    entry_t             q_n_s     [DEPTH];
    entry_t             new_s;
    logic [DEPTH-1:0]   valid_n_s;
    logic [W_CNT-1:0]   count_n_s;
    logic [W_CNT-1:0]   wpos_s;
    logic [W_IDX-1:0]   sel_s;
    logic               issue_valid_s;
    logic               issue_fire_s;
    logic               disp_fire_s;
    logic               dispatch_ready_s;

    // Pick the lowest-index occupied entry whose operands are both present.
    always_comb begin
        issue_valid_s = 1'b0;
        sel_s         = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (valid_r[i] && q_r[i].rsvalid && q_r[i].rtvalid) begin
                issue_valid_s = 1'b1;
                sel_s         = W_IDX'(i);
            end else begin
                issue_valid_s = issue_valid_s;
            end
        end
    end

    assign issue_fire_s = issue_valid_s && issue_ready;

`ifdef ISSUEQ_FULL_PASS_EN
    assign dispatch_ready_s = (count_r < W_CNT'(DEPTH)) || issue_fire_s;
`else
    assign dispatch_ready_s = (count_r < W_CNT'(DEPTH));
`endif

    assign disp_fire_s    = dispatch_en && dispatch_ready_s;
    assign dispatch_ready = dispatch_ready_s;
    assign issue_valid    = issue_valid_s;
    assign count          = count_r;

    // Present the selected entry, zeroing the payload when nothing is issuable.
    always_comb begin
        issue_opcode = 6'd0;
        issue_imm    = 16'd0;
        issue_rdtag  = '0;
        issue_rsdata = '0;
        issue_rtdata = '0;
        if (issue_valid_s) begin
            issue_opcode = q_r[sel_s].opcode;
            issue_imm    = q_r[sel_s].imm;
            issue_rdtag  = q_r[sel_s].rdtag;
            issue_rsdata = q_r[sel_s].rsdata;
            issue_rtdata = q_r[sel_s].rtdata;
        end else begin
            issue_opcode = 6'd0;
        end
    end

    // Next queue image: snoop every entry, close the issue gap, append dispatch.
    always_comb begin
        new_s.opcode  = dispatch_opcode;
        new_s.imm     = dispatch_imm;
        new_s.rdtag   = dispatch_rdtag;
        new_s.rstag   = dispatch_rstag;
        new_s.rttag   = dispatch_rttag;
        new_s.rsdata  = dispatch_rsdata;
        new_s.rtdata  = dispatch_rtdata;
        new_s.rsvalid = dispatch_rsvalid;
        new_s.rtvalid = dispatch_rtvalid;
        new_s         = snoop_fn(new_s, cdb_valid, cdb_tag, cdb_data);

        snp_s[DEPTH] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            snp_s[i] = snoop_fn(q_r[i], cdb_valid, cdb_tag, cdb_data);
        end

        count_n_s = count_r - W_CNT'(issue_fire_s) + W_CNT'(disp_fire_s);
        wpos_s    = count_r - W_CNT'(issue_fire_s);

        for (int i = 0; i < DEPTH; i++) begin
            if (issue_fire_s && (W_IDX'(i) >= sel_s)) begin
                q_n_s[i] = snp_s[i+1];
            end else begin
                q_n_s[i] = snp_s[i];
            end
            if (disp_fire_s && (W_CNT'(i) == wpos_s)) begin
                q_n_s[i] = new_s;
            end else begin
                q_n_s[i] = q_n_s[i];
            end
            valid_n_s[i] = (W_CNT'(i) < count_n_s);
        end
    end

    // Queue state register; asynchronous reset discards every entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= '0;
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_r[i] <= '0;
            end
        end else begin
            valid_r <= valid_n_s;
            count_r <= count_n_s;
            q_r     <= q_n_s;
        end
    end

endmodule
